// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG conditioning path (pair codes, debiaser states, byte width).
package trng_pkg;

    localparam int TRNG_BYTE_W = 8;

    // Pair codes are {first sample, second sample}.
    localparam logic [1:0] PAIR_01 = 2'b01;
    localparam logic [1:0] PAIR_10 = 2'b10;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } vn_state_e;

    function automatic logic vn_pair_valid(input logic [1:0] pair);
        return (pair == PAIR_01) || (pair == PAIR_10);
    endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann extractor: pairs consecutive strobed samples, emits the first sample of an unequal pair.
// Output is combinational in the SECOND-phase strobe cycle; no backpressure (the caller discards).
module trng_vn_debias
    import trng_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_smp_stb,
    input  logic i_smp,
    output logic o_vn_valid,
    output logic o_vn_bit
);

    vn_state_e r_state;
    vn_state_e w_state_nxt;
    logic      r_b0;
    logic [1:0] w_pair;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FIRST;
            r_b0    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_smp_stb && (r_state == FIRST)) begin
                r_b0 <= i_smp;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable) begin
            w_state_nxt = FIRST;
        end else if (i_smp_stb) begin
            case (r_state)
                FIRST:   w_state_nxt = SECOND;
                SECOND:  w_state_nxt = FIRST;
                default: w_state_nxt = FIRST;
            endcase
        end
    end

    always_comb begin
        w_pair     = {r_b0, i_smp};
        o_vn_valid = i_smp_stb && (r_state == SECOND) && vn_pair_valid(w_pair);
        o_vn_bit   = (w_pair == PAIR_10);
    end

endmodule

// File: rtl/trng_conditioner.sv
// Raw entropy sync, decimation, von Neumann debias and byte packing onto a valid/ready port; byte valid on the
// edge its 8th bit lands, stalls full when the holder is busy. Optional repetition health test: TRNG_HEALTH_EN.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_raw_bit,
    input  logic                   i_enable,
    output logic [TRNG_BYTE_W-1:0] o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_health_fail
);

    localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
    localparam logic [3:0] CNT_LAST = 4'(TRNG_BYTE_W - 1);
    localparam logic [3:0] CNT_FULL = 4'(TRNG_BYTE_W);

    // Out-of-range parameters elaborate this marker block so they are easy to spot in a netlist.
    if (SAMPLE_DIV < 1 || SAMPLE_DIV > 255 || REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_param_out_of_range
    end

    logic                   r_s1;
    logic                   r_s2;
    logic [7:0]             r_div_cnt;
    logic                   w_smp_stb;
    logic                   w_vn_valid;
    logic                   w_vn_bit;
    logic [TRNG_BYTE_W-1:0] r_shift;
    logic [3:0]             r_bit_cnt;
    logic [TRNG_BYTE_W-1:0] r_out_data;
    logic                   r_out_valid;
    logic                   w_health_fail;
    logic                   w_hold_free;
    logic                   w_bit_take;
    logic                   w_byte_rdy;
    logic [TRNG_BYTE_W-1:0] w_shift_ins;
    logic [TRNG_BYTE_W-1:0] w_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw_bit;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            r_div_cnt <= 8'd0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= 8'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
        end
    end

    assign w_smp_stb = i_enable && (r_div_cnt == DIV_LAST);

    trng_vn_debias u_vn_debias (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .i_smp_stb  (w_smp_stb),
        .i_smp      (r_s2),
        .o_vn_valid (w_vn_valid),
        .o_vn_bit   (w_vn_bit)
    );

    // Bits arriving while the packer sits full at CNT_FULL are dropped, not queued.
    assign w_hold_free = !o_out_valid || i_out_ready;
    assign w_bit_take  = w_vn_valid && (r_bit_cnt < CNT_FULL);
    assign w_byte_rdy  = (w_bit_take && (r_bit_cnt == CNT_LAST)) || (r_bit_cnt == CNT_FULL);

    always_comb begin
        w_shift_ins = r_shift;
        if (r_bit_cnt < CNT_FULL) begin
            w_shift_ins[r_bit_cnt[2:0]] = w_vn_bit;
        end
        w_byte = (r_bit_cnt == CNT_FULL) ? r_shift : w_shift_ins;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= 4'd0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_health_fail) begin
            r_out_valid <= 1'b0;
            r_bit_cnt   <= 4'd0;
        end else begin
            if (o_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (!i_enable) begin
                r_bit_cnt <= 4'd0;
            end else if (w_byte_rdy && w_hold_free) begin
                r_shift     <= w_byte;
                r_out_data  <= w_byte;
                r_out_valid <= 1'b1;
                r_bit_cnt   <= 4'd0;
            end else if (w_byte_rdy) begin
                r_shift   <= w_byte;
                r_bit_cnt <= CNT_FULL;
            end else if (w_bit_take) begin
                r_shift   <= w_shift_ins;
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

`ifdef TRNG_HEALTH_EN
    localparam logic [7:0] REP_LIM8 = 8'(REP_LIMIT);

    logic       r_health_fail;
    logic [7:0] r_rep_cnt;
    logic       r_rep_prev;
    logic [7:0] w_rep_nxt;

    // A zero count marks "no sample seen yet", so the first sample always starts a run of one.
    always_comb begin
        w_rep_nxt = 8'd1;
        if ((r_rep_cnt != 8'd0) && (r_s2 == r_rep_prev)) begin
            w_rep_nxt = (r_rep_cnt == 8'hFF) ? 8'hFF : (r_rep_cnt + 8'd1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_health_fail <= 1'b0;
            r_rep_cnt     <= 8'd0;
            r_rep_prev    <= 1'b0;
        end else if (w_smp_stb) begin
            r_rep_cnt  <= w_rep_nxt;
            r_rep_prev <= r_s2;
            if (w_rep_nxt >= REP_LIM8) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    assign w_health_fail = r_health_fail;
`else
    assign w_health_fail = 1'b0;
`endif

    assign o_out_data    = r_out_data;
    assign o_out_valid   = r_out_valid && !w_health_fail;
    assign o_health_fail = w_health_fail;

endmodule
